mem_access_stage: RTL and testbench

Memory stage of the 5-stage RV32I pipeline: consumes the execute-to-memory register outputs, performs the load/store against a data memory with a ready handshake, and registers the results into the writeback stage. It owns byte-lane steering, load sign/zero extension, memory wait states, a wait-state watchdog and the resulting pipeline stall.

---
 rtl/mem_access_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// RV32I memory stage: byte-lane steering, load extension, ready-handshake wait states,
// wait-state watchdog and stall. Optional misalignment trap via MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic             MemWriteM,
    input  logic [2:0]       Funct3M,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0] PCPlus4M,
    input  logic [4:0]       RdM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             StallM,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [WIDTH-1:0] ALUResultW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] PCPlus4W,
    output logic [4:0]       RdW,
    output logic             mem_err,
    output logic             misalign_trap
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        we_q, ld_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        err_q, trap_q;

    logic        access_m, misalign_m;
    logic [1:0]  off_m;
    logic [3:0]  be_m;
    logic [31:0] wdata_m;

    logic        req, we_a, ld_a, mis_eff, abort, capture;
    logic [31:0] addr_a, wdata_a;
    logic [3:0]  be_a;
    logic [2:0]  f3_a;
    logic [1:0]  off_a;
    logic [31:0] rd_raw, rd_shift, rd_ext;

    assign access_m = MemWriteM | (ResultSrcM == 2'b01);

    // Lane steering from the M inputs; offsets are naturally aligned per access size.
    always_comb begin
        off_m   = 2'b00;
        be_m    = 4'b1111;
        wdata_m = WriteDataM;
        case (Funct3M)
            3'b000, 3'b100: begin
                off_m   = ALUResultM[1:0];
                be_m    = 4'b0001 << off_m;
                wdata_m = {4{WriteDataM[7:0]}};
            end
            3'b001, 3'b101: begin
                off_m   = {ALUResultM[1], 1'b0};
                be_m    = 4'b0011 << off_m;
                wdata_m = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic raw_mis;
    always_comb begin
        case (Funct3M)
            3'b000, 3'b100: raw_mis = 1'b0;
            3'b001, 3'b101: raw_mis = ALUResultM[0];
            default:        raw_mis = |ALUResultM[1:0];
        endcase
    end
    assign misalign_m = access_m & raw_mis;
`else
    assign misalign_m = 1'b0;
`endif

    always_comb begin
        req     = 1'b0;
        we_a    = 1'b0;
        ld_a    = 1'b0;
        addr_a  = '0;
        wdata_a = '0;
        be_a    = '0;
        f3_a    = 3'b010;
        off_a   = 2'b00;
        mis_eff = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        // The rst term drops the request asynchronously even while M still shows an access.
        if (!rst) begin
            if (state_q == S_WAIT) begin
                req     = 1'b1;
                we_a    = we_q;
                ld_a    = ld_q;
                addr_a  = addr_q;
                wdata_a = wdata_q;
                be_a    = be_q;
                f3_a    = f3_q;
                off_a   = off_q;
            end else if (access_m) begin
                if (misalign_m) begin
                    mis_eff = 1'b1;
                end else begin
                    req     = 1'b1;
                    we_a    = MemWriteM;
                    ld_a    = (ResultSrcM == 2'b01);
                    addr_a  = {ALUResultM[31:2], 2'b00};
                    wdata_a = MemWriteM ? wdata_m : '0;
                    be_a    = be_m;
                    f3_a    = Funct3M;
                    off_a   = off_m;
                end
            end
        end
        abort = (state_q == S_WAIT) && (cnt_q == TO_LAST) && !mem_ready;
        case (state_q)
            S_IDLE: begin
                if (req && !mem_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd1;
                    capture = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ready || abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign StallM = req & ~mem_ready & ~abort;

    assign rd_raw   = abort ? '0 : mem_rdata;
    assign rd_shift = rd_raw >> {off_a, 3'b000};

    always_comb begin
        case (f3_a)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
            3'b101:  rd_ext = {16'd0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            ld_q    <= 1'b0;
            f3_q    <= 3'b010;
            off_q   <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= addr_a;
                wdata_q <= wdata_a;
                be_q    <= be_a;
                we_q    <= we_a;
                ld_q    <= ld_a;
                f3_q    <= f3_a;
                off_q   <= off_a;
            end
            if (abort) err_q <= 1'b1;
        end
    end

    // Stalled cycles inject a bubble into W; data fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            trap_q     <= 1'b0;
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RdW        <= '0;
            trap_q     <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~mis_eff;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (req && ld_a) ? rd_ext : '0;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            trap_q     <= mis_eff;
        end
    end

    assign mem_req       = req;
    assign mem_we        = we_a;
    assign mem_addr      = addr_a;
    assign mem_wdata     = wdata_a;
    assign mem_be        = be_a;
    assign mem_err       = err_q;
    assign misalign_trap = trap_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT = 16).
module tb_mem_access_stage;

    logic        clk, rst;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        StallM, RegWriteW, mem_err, misalign_trap;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
        .mem_err(mem_err), .misalign_trap(misalign_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1);
    end

    task automatic drive_m(input logic rw, input logic [1:0] rs, input logic mw,
                           input logic [2:0] f3, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        Funct3M    = f3;
        ALUResultM = alu;
        WriteDataM = wd;
        PCPlus4M   = pc4;
        RdM        = rd;
    endtask

    task automatic drive_nop();
        drive_m(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 5'd0);
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    endtask

    // Issues an LW and raises mem_ready on request cycle nready (0 = never).
    task automatic run_lw_wait(input logic [31:0] addr, input logic [31:0] rdata,
                               input int nready, output int stalls, output bit done);
        drive_m(1'b1, 2'b01, 1'b0, 3'b010, addr, 32'h0, 32'h80, 5'd12);
        mem_ready = 1'b0;
        mem_rdata = rdata;
        stalls = 0;
        done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            if (cyc == nready) mem_ready = 1'b1;
            #1;
            if (StallM) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        drive_nop();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_nop();
        #3;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", mem_req); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", StallM); end
        checks++; if ({RegWriteW, ResultSrcW, RdW} !== 8'h0) begin errors++; $display("FAIL reset_wctl: got %h exp 0", {RegWriteW, ResultSrcW, RdW}); end
        checks++; if ({ALUResultW, ReadDataW, PCPlus4W} !== 96'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", {ALUResultW, ReadDataW, PCPlus4W}); end
        checks++; if ({mem_err, misalign_trap} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {mem_err, misalign_trap}); end
        #4 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        drive_m(1'b1, 2'b10, 1'b0, 3'b000, 32'h0000CAFE, 32'h5555, 32'h44, 5'd3);
        mem_ready = 1'b1;
        #1;
        checks++; if ({mem_req, mem_we, mem_be} !== 6'h0) begin errors++; $display("FAIL pass_noreq: got %h exp 0", {mem_req, mem_we, mem_be}); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL pass_bus: got %h exp 0", {mem_addr, mem_wdata}); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b exp 0", StallM); end
        @(posedge clk); #1;
        checks++; if (ALUResultW !== 32'h0000CAFE) begin errors++; $display("FAIL pass_alu: got %h exp 0000cafe", ALUResultW); end
        checks++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b10, 5'd3}) begin errors++; $display("FAIL pass_ctl: got %h exp %h", {RegWriteW, ResultSrcW, RdW}, {1'b1, 2'b10, 5'd3}); end
        checks++; if ({PCPlus4W, ReadDataW} !== {32'h44, 32'h0}) begin errors++; $display("FAIL pass_pc_rd: got %h exp %h", {PCPlus4W, ReadDataW}, {32'h44, 32'h0}); end
        drive_nop();
    endtask

    task automatic test_lw();
        drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8, 5'd10);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL lw_stall: got %b exp 0", StallM); end
        checks++; if ({mem_req, mem_we, mem_be} !== {1'b1, 1'b0, 4'hF}) begin errors++; $display("FAIL lw_req: got %h exp %h", {mem_req, mem_we, mem_be}, {1'b1, 1'b0, 4'hF}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h exp 00000100", mem_addr); end
        @(posedge clk); #1;
        checks++; if (ReadDataW !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h exp deadbeef", ReadDataW); end
        checks++; if ({RegWriteW, RdW} !== {1'b1, 5'd10}) begin errors++; $display("FAIL lw_ctl: got %h exp %h", {RegWriteW, RdW}, {1'b1, 5'd10}); end
        drive_nop();
    endtask

    task automatic test_sub_word_loads();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [3:0]  bes [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            drive_m(1'b1, 2'b01, 1'b0, f3s[i], ads[i], 32'h0, 32'h8, 5'd4);
            mem_ready = 1'b1;
            mem_rdata = 32'h80FF0000;
            #1;
            checks++; if ({mem_addr, mem_be} !== {32'h100, bes[i]}) begin errors++; $display("FAIL subld_lane[%0d]: got %h exp %h", i, {mem_addr, mem_be}, {32'h100, bes[i]}); end
            @(posedge clk); #1;
            checks++; if (ReadDataW !== exps[i]) begin errors++; $display("FAIL subld_data[%0d]: got %h exp %h", i, ReadDataW, exps[i]); end
        end
        drive_nop();
    endtask

    task automatic test_store_byte();
        drive_m(1'b0, 2'b00, 1'b1, 3'b000, 32'h201, 32'h000000EF, 32'h10, 5'd0);
        mem_ready = 1'b1;
        #1;
        checks++; if ({mem_we, mem_be, mem_wdata} !== {1'b1, 4'b0010, 32'hEFEFEFEF}) begin errors++; $display("FAIL sb_lane: got %h exp %h", {mem_we, mem_be, mem_wdata}, {1'b1, 4'b0010, 32'hEFEFEFEF}); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL sb_stall: got %b exp 0", StallM); end
        @(posedge clk); #1;
        drive_nop();
    endtask

    task automatic test_sh_wait();
        int  stalls;
        logic was_stall;
        stalls = 0;
        drive_m(1'b0, 2'b00, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h30, 5'd7);
        mem_ready = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            if (cyc == 4) mem_ready = 1'b1;
            #1;
            checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h200, 32'hABCDABCD}) begin
                errors++; $display("FAIL sh_req[%0d]: got %h exp %h", cyc, {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'b1100, 32'h200, 32'hABCDABCD});
            end
            was_stall = StallM;
            if (StallM) stalls++;
            if (cyc == 2) WriteDataM = 32'hFFFF0000;
            @(posedge clk); #1;
            if (was_stall) begin
                checks++; if ({RegWriteW, RdW, ResultSrcW} !== 8'h0) begin errors++; $display("FAIL sh_bubble[%0d]: got %h exp 0", cyc, {RegWriteW, RdW, ResultSrcW}); end
            end
        end
        checks++; if (stalls !== 3) begin errors++; $display("FAIL sh_stall_cycles: got %0d exp 3", stalls); end
        checks++; if ({RdW, ALUResultW, ReadDataW} !== {5'd7, 32'h202, 32'h0}) begin errors++; $display("FAIL sh_retire: got %h exp %h", {RdW, ALUResultW, ReadDataW}, {5'd7, 32'h202, 32'h0}); end
        drive_nop();
    endtask

    task automatic test_ready_wins();
        int s; bit d;
        run_lw_wait(32'h400, 32'hA5A50001, 16, s, d);
        checks++; if (d !== 1'b1 || s !== 15) begin errors++; $display("FAIL rw_stalls: got done=%0d stalls=%0d exp done=1 stalls=15", d, s); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rw_err: got %b exp 0", mem_err); end
        checks++; if (ReadDataW !== 32'hA5A50001) begin errors++; $display("FAIL rw_data: got %h exp a5a50001", ReadDataW); end
    endtask

    task automatic test_timeout();
        int s; bit d;
        run_lw_wait(32'h300, 32'hFFFFFFFF, 0, s, d);
        checks++; if (d !== 1'b1 || s !== 15) begin errors++; $display("FAIL to_stalls: got done=%0d stalls=%0d exp done=1 stalls=15", d, s); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b exp 1", mem_err); end
        checks++; if (ReadDataW !== 32'h0) begin errors++; $display("FAIL to_data: got %h exp 0", ReadDataW); end
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_idle: got %b exp 0", mem_req); end
        run_lw_wait(32'h304, 32'h11223344, 1, s, d);
        checks++; if (d !== 1'b1 || s !== 0) begin errors++; $display("FAIL to_next_stalls: got done=%0d stalls=%0d exp done=1 stalls=0", d, s); end
        checks++; if ({mem_err, ReadDataW} !== {1'b1, 32'h11223344}) begin errors++; $display("FAIL to_next: got %h exp %h", {mem_err, ReadDataW}, {1'b1, 32'h11223344}); end
    endtask

    task automatic test_reset_mid();
        int s; bit d;
        drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h500, 32'h0, 32'h90, 5'd9);
        mem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #1;
        checks++; if ({mem_req, StallM} !== 2'b11) begin errors++; $display("FAIL rm_pre: got %b exp 11", {mem_req, StallM}); end
        #1 rst = 1'b1;
        #1;
        checks++; if ({mem_req, StallM} !== 2'b00) begin errors++; $display("FAIL rm_async_drop: got %b exp 00", {mem_req, StallM}); end
        checks++; if ({RegWriteW, ResultSrcW, RdW, mem_err} !== 9'h0) begin errors++; $display("FAIL rm_wctl: got %h exp 0", {RegWriteW, ResultSrcW, RdW, mem_err}); end
        checks++; if ({ALUResultW, ReadDataW, PCPlus4W} !== 96'h0) begin errors++; $display("FAIL rm_wdata: got %h exp 0", {ALUResultW, ReadDataW, PCPlus4W}); end
        drive_nop();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_lw_wait(32'h504, 32'h0BADF00D, 16, s, d);
        checks++; if (d !== 1'b1 || s !== 15) begin errors++; $display("FAIL rm_restart: got done=%0d stalls=%0d exp done=1 stalls=15", d, s); end
        checks++; if ({mem_err, ReadDataW} !== {1'b0, 32'h0BADF00D}) begin errors++; $display("FAIL rm_restart_data: got %h exp %h", {mem_err, ReadDataW}, {1'b0, 32'h0BADF00D}); end
    endtask

    task automatic test_misalign();
        drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'h0, 32'h8, 5'd6);
        mem_ready = 1'b1;
        mem_rdata = 32'h55667788;
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if ({mem_req, StallM} !== 2'b00) begin errors++; $display("FAIL mis_noreq: got %b exp 00", {mem_req, StallM}); end
        @(posedge clk); #1;
        checks++; if ({misalign_trap, RegWriteW, RdW} !== {1'b1, 1'b0, 5'd6}) begin errors++; $display("FAIL mis_trap: got %h exp %h", {misalign_trap, RegWriteW, RdW}, {1'b1, 1'b0, 5'd6}); end
        drive_nop();
        @(posedge clk); #1;
        checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL mis_trap_pulse: got %b exp 0", misalign_trap); end
`else
        checks++; if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h100, 4'hF}) begin errors++; $display("FAIL mis_aligned_req: got %h exp %h", {mem_req, mem_addr, mem_be}, {1'b1, 32'h100, 4'hF}); end
        @(posedge clk); #1;
        checks++; if ({ReadDataW, RegWriteW, misalign_trap} !== {32'h55667788, 1'b1, 1'b0}) begin errors++; $display("FAIL mis_load: got %h exp %h", {ReadDataW, RegWriteW, misalign_trap}, {32'h55667788, 1'b1, 1'b0}); end
        drive_nop();
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lw();
        test_sub_word_loads();
        test_store_byte();
        test_sh_wait();
        test_ready_wins();
        test_timeout();
        test_reset_mid();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
